// File: rtl/tape_pkg.sv
// Shared types and constants for the tape prefetch block.
package tape_pkg;

    // Prefetch sequencer states; exported on o_state for observation.
    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FLUSH = 3'd4
    } tape_state_e;

    // SDRAM bank that holds the tape image.
    localparam logic [1:0] TAPE_BANK = 2'b10;

endpackage

// File: rtl/tape_fifo.sv
// Small first-word-fall-through FIFO. o_dout always shows the head entry.
// Clear has priority over push and pop; pop on empty and push on full are dropped.
module tape_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/tape_prefetch.sv
// Streams a byte range out of the SDRAM tape bank through a toggle-ack read
// port and presents it on a valid/ready byte stream via a small FIFO.
// Output stream handshake: a byte transfers on any rising clk edge where
// o_out_valid and i_out_ready are both high; o_out_data is stable while
// o_out_valid is high and the consumer has not taken it.
module tape_prefetch
    import tape_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_length,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_tape_addr,
    output logic              o_tape_rd,
    input  logic              i_tape_rd_ack,
    input  logic [7:0]        i_tape_dout,
    output logic [7:0]        o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_tape_bank,
    output tape_state_e       o_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tape_state_e       r_state, w_state_nxt;
    logic              r_ack_seen;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_rem, w_rem_nxt;
    logic [ADDR_W-1:0] r_tape_addr, w_addr_nxt;
    logic              r_tape_rd, w_rd_nxt;
    logic              r_done, w_done_nxt;
    logic              w_push;
    logic              w_clear;
    logic              w_ack_evt;
    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;

    assign w_ack_evt   = i_tape_rd_ack ^ r_ack_seen;
    assign o_tape_addr = r_tape_addr;
    assign o_tape_rd   = r_tape_rd;
    assign o_done      = r_done;
    assign o_out_valid = !w_empty;
    assign o_tape_bank = TAPE_BANK;
    assign o_state     = r_state;
    assign o_busy      = !(r_state == ST_IDLE || r_state == ST_SYNC) || (w_count != '0);

    tape_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (i_tape_dout),
        .i_pop   (i_out_ready),
        .i_clear (w_clear),
        .o_dout  (o_out_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Sequencer registers; the ack level is re-sampled every cycle (SYNC included)
    // because the controller's ack toggle has no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SYNC;
            r_ack_seen  <= 1'b0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_tape_addr <= '0;
            r_tape_rd   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack_seen  <= i_tape_rd_ack;
            r_ptr       <= w_ptr_nxt;
            r_rem       <= w_rem_nxt;
            r_tape_addr <= w_addr_nxt;
            r_tape_rd   <= w_rd_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state and datapath control; abort outranks start and ack events.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        w_addr_nxt  = r_tape_addr;
        w_rd_nxt    = r_tape_rd;
        w_done_nxt  = 1'b0;
        w_push      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_abort) begin
                    w_clear = 1'b1;
                end else if (i_start) begin
                    w_ptr_nxt = i_base_addr;
                    w_rem_nxt = i_length;
                    if (i_length == '0) w_done_nxt  = 1'b1;
                    else                w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_full) begin
                    w_addr_nxt  = r_ptr;
                    w_rd_nxt    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    // A read completing on the abort cycle is already drained.
                    w_clear     = 1'b1;
                    w_rd_nxt    = 1'b0;
                    w_state_nxt = w_ack_evt ? ST_IDLE : ST_FLUSH;
                end else if (w_ack_evt) begin
                    w_rd_nxt  = 1'b0;
                    w_push    = 1'b1;
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                    w_rem_nxt = r_rem - ADDR_W'(1);
                    if (r_rem == ADDR_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_ack_evt) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_tape_prefetch.sv
// Bench for tape_prefetch: SDRAM toggle-ack model, byte scoreboard, directed and random runs.
module tb_tape_prefetch;
  import tape_pkg::*;

  localparam int AW    = 23;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_start = 1'b0;
  logic [AW-1:0]     i_base_addr = '0;
  logic [AW-1:0]     i_length = '0;
  logic              i_abort = 1'b0;
  logic [AW-1:0]     o_tape_addr;
  logic              o_tape_rd;
  logic              i_tape_rd_ack = 1'b0;
  logic [7:0]        i_tape_dout = '0;
  logic [7:0]        o_out_data;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_tape_bank;
  tape_state_e       o_state;

  tape_prefetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .i_abort(i_abort), .o_tape_addr(o_tape_addr),
    .o_tape_rd(o_tape_rd), .i_tape_rd_ack(i_tape_rd_ack), .i_tape_dout(i_tape_dout),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_tape_bank(o_tape_bank), .o_state(o_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int ack_delay = 8;
  logic [7:0] salt = 8'h00;
  logic ready_rand = 1'b0;
  logic ready_fix = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference memory content: one byte per address, shifted by a per-run salt.
  function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
    return a[7:0] + salt;
  endfunction

  // ---------------- SDRAM tape port model ----------------
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && o_tape_rd) begin
        rd_cnt++;
        a = o_tape_addr;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr %0h expected no read", a);
        end else begin
          check("tape_addr", 32'(a), 32'(addr_q.pop_front()));
        end
        repeat (ack_delay) @(posedge clk);
        #1;
        i_tape_dout = byte_at(a);
        i_tape_rd_ack = ~i_tape_rd_ack;
        @(posedge clk);
        @(negedge clk);
        check("rd_release", 32'(o_tape_rd), 32'd0);
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_out_valid && i_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", o_out_data);
          end else begin
            check("out_data", 32'(o_out_data), 32'(exp_q.pop_front()));
          end
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back(byte_at(a));
    end
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_base_addr = base;
    i_length = len;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((o_busy || exp_q.size() != 0 || addr_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < max_cyc), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, r0, n;
    logic [AW-1:0] rb, rl;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tape_addr", 32'(o_tape_addr), 32'd0);
    check("rst_tape_rd", 32'(o_tape_rd), 32'd0);
    check("rst_out_data", 32'(o_out_data), 32'd0);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_state", 32'(o_state), 32'(ST_SYNC));
    check("tape_bank", 32'(o_tape_bank), 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("sync_state", 32'(o_state), 32'(ST_SYNC));
    @(negedge clk);
    check("idle_state", 32'(o_state), 32'(ST_IDLE));

    // Basic stream
    salt = 8'hA1; ack_delay = 8; ready_fix = 1'b1;
    d0 = done_cnt; r0 = rd_cnt;
    start_xfer(23'h000100, 23'd3);
    wait_idle("basic_timeout", 200);
    check("basic_done", 32'(done_cnt - d0), 32'd1);
    check("basic_reads", 32'(rd_cnt - r0), 32'd3);
    check("basic_rd_low", 32'(o_tape_rd), 32'd0);

    // Backpressure
    salt = 8'h37; ack_delay = 3; ready_fix = 1'b0;
    d0 = done_cnt; r0 = rd_cnt;
    start_xfer(23'h002000, 23'd6);
    repeat (60) @(negedge clk);
    check("bp_reads_held", 32'(rd_cnt - r0), 32'd4);
    check("bp_rd_low", 32'(o_tape_rd), 32'd0);
    check("bp_valid", 32'(o_out_valid), 32'd1);
    check("bp_state", 32'(o_state), 32'(ST_REQ));
    ready_fix = 1'b1;
    wait_idle("bp_timeout", 300);
    check("bp_reads_all", 32'(rd_cnt - r0), 32'd6);
    check("bp_done", 32'(done_cnt - d0), 32'd1);

    // Address wrap
    salt = 8'h5C; ack_delay = 4;
    d0 = done_cnt;
    start_xfer(23'h7FFFFF, 23'd2);
    wait_idle("wrap_timeout", 200);
    check("wrap_done", 32'(done_cnt - d0), 32'd1);

    // Zero length
    d0 = done_cnt; r0 = rd_cnt;
    start_xfer(23'h001234, 23'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(o_done), 32'd1);
    @(negedge clk);
    check("zero_done_clear", 32'(o_done), 32'd0);
    repeat (5) @(negedge clk);
    check("zero_no_read", 32'(rd_cnt - r0), 32'd0);
    check("zero_state", 32'(o_state), 32'(ST_IDLE));
    check("zero_done_count", 32'(done_cnt - d0), 32'd1);

    // Abort while a read is outstanding
    salt = 8'h11; ack_delay = 8;
    d0 = done_cnt; r0 = rd_cnt;
    start_xfer(23'h000300, 23'd3);
    n = 0;
    while (!o_tape_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_rd_seen", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 i_abort = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1 i_abort = 1'b0;
    @(negedge clk);
    check("abort_rd_drop", 32'(o_tape_rd), 32'd0);
    check("abort_valid", 32'(o_out_valid), 32'd0);
    check("abort_flush", 32'(o_state), 32'(ST_FLUSH));
    n = 0;
    while (o_state != ST_IDLE && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_idle", 32'(o_state), 32'(ST_IDLE));
    repeat (4) @(negedge clk);
    check("abort_valid_after", 32'(o_out_valid), 32'd0);
    check("abort_reads", 32'(rd_cnt - r0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    start_xfer(23'h000400, 23'd1);
    wait_idle("post_abort_timeout", 200);
    check("post_abort_done", 32'(done_cnt - d0), 32'd1);

    // Ack held high across reset release
    @(posedge clk);
    #1 i_tape_rd_ack = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rsync_state", 32'(o_state), 32'(ST_IDLE));
    check("rsync_no_push", 32'(o_out_valid), 32'd0);
    salt = 8'hE0; ack_delay = 5;
    d0 = done_cnt;
    start_xfer(23'h000500, 23'd1);
    wait_idle("rsync_timeout", 200);
    check("rsync_done", 32'(done_cnt - d0), 32'd1);
    check("rsync_ack_level", 32'(i_tape_rd_ack), 32'd0);

    // Randomized runs with random consumer backpressure
    ready_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      salt = 8'($urandom);
      ack_delay = $urandom_range(1, 10);
      rb = AW'($urandom);
      rl = AW'($urandom_range(1, 9));
      d0 = done_cnt; r0 = rd_cnt;
      start_xfer(rb, rl);
      wait_idle("rand_timeout", 600);
      check("rand_done", 32'(done_cnt - d0), 32'd1);
      check("rand_reads", 32'(rd_cnt - r0), 32'(rl));
    end
    ready_rand = 1'b0;
    repeat (3) @(negedge clk);
    check("final_busy", 32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tape_prefetch.md
Name: tape_prefetch

Overview:
- Upstream feeder for the SDRAM controller's tape port.
- Streams a programmed byte range out of SDRAM bank 2 using the tape_rd / tape_rd_ack toggle handshake.
- Buffers the fetched bytes in a small FIFO and presents them to the tape playback logic on a valid/ready byte stream.
- Hides SDRAM slot latency from the playback logic.

Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, minimum 2.
- ADDR_W, 23: byte address width; matches the SDRAM tape_addr width.

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and length and begins streaming.
- base_addr  in  ADDR_W  first byte address.
- length  in  ADDR_W  number of bytes to stream; 0 is legal.
- abort  in  1  one-cycle pulse; stops streaming and empties the FIFO.
- tape_addr  out  ADDR_W  read address to the SDRAM controller.
- tape_rd  out  1  read request level to the SDRAM controller.
- tape_rd_ack  in  1  toggles once per completed read.
- tape_dout  in  8  read data; valid on the cycle tape_rd_ack toggles.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head byte when out_valid is also high.
- busy  out  1  state is not IDLE/SYNC, or the FIFO is not empty.
- done  out  1  one-cycle pulse when the last byte of the range has been pushed into the FIFO.

Behaviour:
- Reset values: tape_addr=0, tape_rd=0, out_data=0, out_valid=0, busy=0, done=0, FIFO empty, state=SYNC.
- Toggle detection:
  - ack_seen register holds the last observed tape_rd_ack level.
  - ack_evt = tape_rd_ack ^ ack_seen.
  - ack_seen <= tape_rd_ack every cycle after SYNC.
- FSM states and transitions:
  - SYNC: ack_seen <= tape_rd_ack (the controller's ack has no reset); next state IDLE. This occupies exactly one cycle after reset release.
  - IDLE: on start, ptr <= base_addr and remaining <= length.
    - length==0: done pulses the next cycle; stay in IDLE.
    - Otherwise: go to REQ.
  - REQ: when FIFO free entries >= 1 (count < FIFO_DEPTH), drive tape_addr <= ptr and tape_rd <= 1, then go to WAIT. Otherwise hold in REQ with tape_rd=0.
  - WAIT:
    - tape_rd and tape_addr are held stable until ack_evt.
    - On ack_evt: tape_rd <= 0; push tape_dout into the FIFO; ptr <= ptr+1, wrapping modulo 2^ADDR_W; remaining <= remaining-1.
    - If remaining==1: pulse done and go to IDLE. Otherwise go to REQ.
  - FLUSH: entered on abort while in WAIT.
    - tape_rd <= 0 immediately.
    - Wait for ack_evt, discard that byte, then go to IDLE.
- At most one read is outstanding. tape_rd deasserts within 1 cycle of the ack, well inside the controller's idle-slot spacing, so no duplicate read is issued.
- FIFO:
  - Synchronous, first-word-fall-through; out_data = head.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop when empty is ignored.
  - Push is never attempted when full, because REQ gates on free space.
- abort:
  - In IDLE or REQ: go to IDLE and clear the FIFO.
  - In WAIT: go to FLUSH and clear the FIFO.
  - In FLUSH: ignored.
  - done is suppressed after an abort.
- start is ignored in every state except IDLE.
- start and abort in the same cycle: abort wins.
- Asynchronous reset mid-transfer: all state is cleared and the FSM re-enters SYNC. A controller read still in flight completes; its ack toggle is absorbed by SYNC re-sampling or discarded in IDLE, because ack_evt is ignored outside WAIT/FLUSH.

Decomposition:
- Shared package tape_pkg holds:
  - the state enum (SYNC, IDLE, REQ, WAIT, FLUSH);
  - the constant TAPE_BANK=2'b10.
- One natural sub-module: tape_fifo, a parameterised FWFT byte FIFO with push, pop, clear, count, empty and full.

Test Plan:
- Basic stream: reset, start with base=0x000100 and len=3; model returns 0xA1, 0xA2, 0xA3 with ack toggles 8 cycles apart; out_ready=1 → tape_addr sequence 0x100, 0x101, 0x102, out_data sequence A1, A2, A3, done pulses once after the third ack, tape_rd low by the end.
- Backpressure: FIFO_DEPTH=4, len=6, out_ready=0 → exactly 4 reads are issued, then tape_rd stays 0 and out_valid=1. Raising out_ready drains the FIFO and the remaining 2 reads follow, with no byte lost or duplicated.
- Wrap: base=0x7FFFFF, len=2 → tape_addr 0x7FFFFF, then 0x000000.
- Zero length: start with len=0 → no tape_rd and done pulses one cycle later.
- Abort in WAIT: abort 2 cycles after tape_rd rises, then the ack toggles 6 cycles later → tape_rd drops immediately, the byte is discarded, out_valid=0, and the state returns to IDLE. A following start with len=1 fetches correctly.
- Reset sync: hold tape_rd_ack=1 across reset release, then start with len=1 → no spurious push before the first real toggle (1→0).
